// File: rtl/rf_wb_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 32;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t          sel;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at a registered
// pointer, pointer moves one past the winner on every grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                       clk,
  input  logic                       reset_ni,
  input  logic [NUM_REQ-1:0]         valid,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] idx_c
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CW    = IDX_W + 1;

  logic [IDX_W-1:0] ptr;
  logic [CW-1:0]    cand;
  logic             found;

  // Scan from ptr, wrapping modulo NUM_REQ; no grant while in reset.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!found && reset_ni && valid[cand[IDX_W-1:0]]) begin
        found                     = 1'b1;
        grant_c[cand[IDX_W-1:0]]  = 1'b1;
        idx_c                     = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : idx_c + IDX_W'(1);
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources and
// tracks pending destinations. Optional forwarding path: RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = rf_wb_pkg::DATA_W,
  parameter int unsigned ADDR_W  = rf_wb_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_sel_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic                      issue_valid_i,
  input  logic [ADDR_W-1:0]         issue_sel_i,
  output logic [DATA_W-1:0]         rf_in_o,
  output logic [ADDR_W-1:0]         rf_in_sel_o,
  output logic                      rf_in_en_o,
  output logic [(2**ADDR_W)-1:0]    busy_o
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]         rd1_sel_i,
  input  logic [ADDR_W-1:0]         rd2_sel_i,
  input  logic [DATA_W-1:0]         rf_out1_i,
  input  logic [DATA_W-1:0]         rf_out2_i,
  output logic [DATA_W-1:0]         fwd_out1_o,
  output logic [DATA_W-1:0]         fwd_out2_o
`endif
);

  import rf_wb_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned REGS  = 2 ** ADDR_W;

  logic [IDX_W-1:0]  win_idx;
  logic              xfer;
  logic [ADDR_W-1:0] win_sel;
  logic [DATA_W-1:0] win_data;
  logic [REGS-1:0]   busy_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .reset_ni (reset_ni),
    .valid    (req_valid_i),
    .grant_c  (req_ready_o),
    .idx_c    (win_idx)
  );

  assign xfer = |(req_valid_i & req_ready_o);

  always_comb begin
    win_sel  = req_sel_i[int'(win_idx)*ADDR_W +: ADDR_W];
    win_data = req_data_i[int'(win_idx)*DATA_W +: DATA_W];
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      rf_in_o     <= '0;
      rf_in_sel_o <= '0;
      rf_in_en_o  <= 1'b0;
    end else if (xfer) begin
      rf_in_o     <= win_data;
      rf_in_sel_o <= win_sel;
      rf_in_en_o  <= (win_sel != '0);
    end else begin
      rf_in_en_o  <= 1'b0;
    end
  end

  // A new issue to the register being retired wins over the clear.
  always_comb begin
    busy_n = busy_o;
    if (rf_in_en_o) busy_n[rf_in_sel_o] = 1'b0;
    if (issue_valid_i && (issue_sel_i != '0)) busy_n[issue_sel_i] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) busy_o <= '0;
    else           busy_o <= busy_n;
  end

`ifdef RF_WB_BYPASS_EN
  assign fwd_out1_o = (rf_in_en_o && (rf_in_sel_o == rd1_sel_i)) ? rf_in_o : rf_out1_i;
  assign fwd_out2_o = (rf_in_en_o && (rf_in_sel_o == rd2_sel_i)) ? rf_in_o : rf_out2_i;
`endif

`ifndef SYNTHESIS
  logic [7:0] wait_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!reset_ni || !req_valid_i[k] || req_ready_o[k]) wait_cnt[k] <= '0;
      else                                                 wait_cnt[k] <= wait_cnt[k] + 8'd1;
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready_o));

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_starve
    a_no_starve: assert property (@(posedge clk) disable iff (!reset_ni)
                                  wait_cnt[k] < 8'(NUM_REQ));
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a small register-file model.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int unsigned NUM_REQ = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset_ni;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_sel;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      issue_valid;
  reg_idx_t                  issue_sel;
  logic [DATA_W-1:0]         rf_in;
  reg_idx_t                  rf_in_sel;
  logic                      rf_in_en;
  logic [REG_COUNT-1:0]      busy;
`ifdef RF_WB_BYPASS_EN
  reg_idx_t                  rd1_sel, rd2_sel;
  logic [DATA_W-1:0]         rf_out1, rf_out2, fwd_out1, fwd_out2;
`endif

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] rf_model [REG_COUNT];

  rf_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset_ni      (reset_ni),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_sel_i     (req_sel),
    .req_data_i    (req_data),
    .issue_valid_i (issue_valid),
    .issue_sel_i   (issue_sel),
    .rf_in_o       (rf_in),
    .rf_in_sel_o   (rf_in_sel),
    .rf_in_en_o    (rf_in_en),
    .busy_o        (busy)
`ifdef RF_WB_BYPASS_EN
    ,
    .rd1_sel_i     (rd1_sel),
    .rd2_sel_i     (rd2_sel),
    .rf_out1_i     (rf_out1),
    .rf_out2_i     (rf_out2),
    .fwd_out1_o    (fwd_out1),
    .fwd_out2_o    (fwd_out2)
`endif
  );

  // Register-file model: writes any index the DUT enables, including x0.
  always @(posedge clk) begin
    if (rf_in_en === 1'b1) rf_model[rf_in_sel] <= rf_in;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input reg_idx_t s, input logic [DATA_W-1:0] d);
    req_sel[k*ADDR_W +: ADDR_W]  = s;
    req_data[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0; req_valid = '1; issue_valid = 1'b1; issue_sel = 5'd3;
    set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2); set_req(2, 5'd3, 32'h3);
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", req_ready); end
      checks++; if (rf_in_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", rf_in_en); end
      checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
    end
    checks++; if (rf_in !== '0 || rf_in_sel !== '0) begin errors++; $display("FAIL reset_out: got %h/%0d want 0/0", rf_in, rf_in_sel); end
    reset_ni = 1'b1; issue_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_first_grant: got %b want 001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single_write();
    set_req(1, 5'd5, 32'hDEADBEEF); req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b want 010", req_ready); end
    step(); req_valid = '0;
    checks++; if (rf_in_en !== 1'b1) begin errors++; $display("FAIL single_en: got %b want 1", rf_in_en); end
    checks++; if (rf_in_sel !== 5'd5) begin errors++; $display("FAIL single_sel: got %0d want 5", rf_in_sel); end
    checks++; if (rf_in !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", rf_in); end
    step();
    checks++; if (rf_model[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rf_x5: got %h want deadbeef", rf_model[5]); end
    checks++; if (rf_in_en !== 1'b0) begin errors++; $display("FAIL single_en_drop: got %b want 0", rf_in_en); end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_g [6];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    set_req(0, 5'd10, 32'h100); set_req(1, 5'd11, 32'h101); set_req(2, 5'd12, 32'h102);
    // Pointer sits at 2 after the single write; one grant to 2 returns it to 0.
    req_valid = 3'b100;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL fair_pre_ready: got %b want 100", req_ready); end
    step();
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (req_ready !== exp_g[i]) begin errors++; $display("FAIL fair_grant[%0d]: got %b want %b", i, req_ready, exp_g[i]); end
      step();
      checks++; if (rf_in_sel !== 5'(10 + (i % 3)) || rf_in_en !== 1'b1) begin
        errors++; $display("FAIL fair_write[%0d]: got sel %0d en %b want sel %0d en 1", i, rf_in_sel, rf_in_en, 10 + (i % 3));
      end
    end
    req_valid = 3'b100;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL fair_alone_ready: got %b want 100", req_ready); end
    step(); req_valid = '0;
    checks++; if (rf_in_sel !== 5'd12) begin errors++; $display("FAIL fair_alone_sel: got %0d want 12", rf_in_sel); end
  endtask

  task automatic test_x0_discard();
    set_req(0, 5'd0, 32'h1234); req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready: got %b want 001", req_ready); end
    step(); req_valid = '0;
    checks++; if (rf_in_en !== 1'b0) begin errors++; $display("FAIL x0_en: got %b want 0", rf_in_en); end
    checks++; if (rf_in !== 32'h1234 || rf_in_sel !== 5'd0) begin errors++; $display("FAIL x0_stage: got %h/%0d want 1234/0", rf_in, rf_in_sel); end
    step();
    checks++; if (rf_model[0] !== 32'h0) begin errors++; $display("FAIL x0_rf: got %h want 0", rf_model[0]); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_sel = 5'd7;
    step(); issue_valid = 1'b0;
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_set: got %b want 1", busy[7]); end
    step(); step();
    set_req(1, 5'd7, 32'h77); req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL sb_ready: got %b want 010", req_ready); end
    step(); req_valid = '0;
    checks++; if (rf_in_en !== 1'b1 || rf_in_sel !== 5'd7) begin errors++; $display("FAIL sb_write: got en %b sel %0d want 1/7", rf_in_en, rf_in_sel); end
    issue_valid = 1'b1; issue_sel = 5'd7;
    step(); issue_valid = 1'b0;
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b want 1", busy[7]); end
    set_req(2, 5'd7, 32'h78); req_valid = 3'b100;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL sb_ready2: got %b want 100", req_ready); end
    step(); req_valid = '0;
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_hold: got %b want 1", busy[7]); end
    step();
    checks++; if (busy !== '0) begin errors++; $display("FAIL sb_clear: got %h want 0", busy); end
    issue_valid = 1'b1; issue_sel = 5'd0;
    step(); issue_valid = 1'b0;
    checks++; if (busy !== '0) begin errors++; $display("FAIL sb_x0: got %h want 0", busy); end
  endtask

  task automatic test_reset_mid();
    set_req(0, 5'd3, 32'hCAFE); req_valid = 3'b001;
    issue_valid = 1'b1; issue_sel = 5'd8;
    step(); req_valid = '0; issue_valid = 1'b0;
    checks++; if (rf_in_en !== 1'b1 || busy[8] !== 1'b1) begin errors++; $display("FAIL mid_pre: got en %b busy8 %b want 1/1", rf_in_en, busy[8]); end
    reset_ni = 1'b0;
    step();
    checks++; if (rf_in_en !== 1'b0) begin errors++; $display("FAIL mid_en: got %b want 0", rf_in_en); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL mid_busy: got %h want 0", busy); end
    checks++; if (rf_in !== '0 || rf_in_sel !== '0) begin errors++; $display("FAIL mid_out: got %h/%0d want 0/0", rf_in, rf_in_sel); end
    reset_ni = 1'b1;
  endtask

`ifdef RF_WB_BYPASS_EN
  task automatic test_bypass();
    set_req(0, 5'd9, 32'hA5A5A5A5); req_valid = 3'b001;
    step(); req_valid = '0;
    rd1_sel = 5'd9; rf_out1 = 32'h0; rd2_sel = 5'd10; rf_out2 = 32'h13579BDF;
    #1;
    checks++; if (fwd_out1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_fwd1: got %h want a5a5a5a5", fwd_out1); end
    checks++; if (fwd_out2 !== 32'h13579BDF) begin errors++; $display("FAIL byp_fwd2: got %h want 13579bdf", fwd_out2); end
    step(); rf_out1 = 32'h11;
    #1;
    checks++; if (fwd_out1 !== 32'h11) begin errors++; $display("FAIL byp_idle: got %h want 11", fwd_out1); end
  endtask
`endif

  initial begin
    for (int r = 0; r < REG_COUNT; r++) rf_model[r] = '0;
    reset_ni = 1'b0; req_valid = '0; req_sel = '0; req_data = '0;
    issue_valid = 1'b0; issue_sel = '0;
`ifdef RF_WB_BYPASS_EN
    rd1_sel = '0; rd2_sel = '0; rf_out1 = '0; rf_out2 = '0;
`endif
    test_reset();
    test_single_write();
    test_fairness();
    test_x0_discard();
    test_scoreboard();
    test_reset_mid();
`ifdef RF_WB_BYPASS_EN
    test_bypass();
`endif
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
